// File: rtl/vedic_mac_acc.sv
// Block multiply-accumulate: registered operand pairs go through a combinational
// Vedic 8x8 multiplier, and N products are summed into one held output block.

module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1, c2, cy, t;

  assign c1   = a[1] & b[0];
  assign c2   = a[0] & b[1];
  assign cy   = c1 & c2;
  assign t    = a[1] & b[1];
  assign p[0] = a[0] & b[0];
  assign p[1] = c1 ^ c2;
  assign p[2] = t ^ cy;
  assign p[3] = t & cy;
endmodule

module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;

  vedic_2x2 u_q0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic_2x2 u_q1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic_2x2 u_q2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic_2x2 u_q3 (.a(a[3:2]), .b(b[3:2]), .p(q3));

  // Urdhva-tiryagbhyam: cross terms land two bits up, the high term four bits up.
  assign p = 8'(q0) + (8'(q1) << 2) + (8'(q2) << 2) + (8'(q3) << 4);
endmodule

module vedic_8X8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] q0, q1, q2, q3;

  vedic_4x4 u_q0 (.a(a[3:0]), .b(b[3:0]), .p(q0));
  vedic_4x4 u_q1 (.a(a[7:4]), .b(b[3:0]), .p(q1));
  vedic_4x4 u_q2 (.a(a[3:0]), .b(b[7:4]), .p(q2));
  vedic_4x4 u_q3 (.a(a[7:4]), .b(b[7:4]), .p(q3));

  assign p = 16'(q0) + (16'(q1) << 4) + (16'(q2) << 4) + (16'(q3) << 8);
endmodule

module vedic_mac_acc #(
  parameter int unsigned N     = 4,
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned EW = ACC_W + 1;
  localparam logic [CW-1:0] N_C   = CW'(N);
  localparam logic [CW-1:0] N_M1  = CW'(N - 1);
  localparam logic [0:0]    S_ACC  = 1'b0;
  localparam logic [0:0]    S_HOLD = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt_in, cnt_acc;
  logic [7:0]       a_r, b_r;
  logic             v1, v2;
  logic [15:0]      prod, p_r;
  logic [ACC_W-1:0] acc;
  logic [EW-1:0]    acc_ext;
  logic             accept;

  vedic_8X8 u_mul (.a(a_r), .b(b_r), .p(prod));

  assign in_ready  = (state == S_ACC) && (cnt_in < N_C) && !clr;
  assign accept    = in_valid && in_ready;
  assign acc_ext   = {1'b0, acc} + EW'(p_r);
  assign out_valid = (state == S_HOLD);
  assign sum       = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_ACC;
      cnt_in  <= '0;
      cnt_acc <= '0;
      a_r     <= '0;
      b_r     <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      p_r     <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
    end else if (clr) begin
      state   <= S_ACC;
      cnt_in  <= '0;
      cnt_acc <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      acc     <= '0;
      ovf     <= 1'b0;
    end else begin
      v1  <= accept;
      v2  <= v1;
      p_r <= prod;
      if (accept) begin
        a_r    <= a;
        b_r    <= b;
        cnt_in <= cnt_in + CW'(1);
      end
      // No product can be in flight while holding: all N were already summed.
      if (state == S_HOLD) begin
        if (out_ready) begin
          state   <= S_ACC;
          cnt_in  <= '0;
          cnt_acc <= '0;
          acc     <= '0;
          ovf     <= 1'b0;
        end
      end else if (v2) begin
        acc     <= acc_ext[ACC_W-1:0];
        ovf     <= ovf | acc_ext[ACC_W];
        cnt_acc <= cnt_acc + CW'(1);
        if (cnt_acc == N_M1) state <= S_HOLD;
      end
    end
  end
endmodule

// File: doc/vedic_mac_acc.md
Name: vedic_mac_acc

Overview:
Sequential multiply-accumulate stage that sits downstream of the existing combinational 8x8 Vedic multiplier (vedic_8X8). It accepts a stream of 8-bit operand pairs through a valid/ready handshake and registers them. It feeds them to one vedic_8X8 instance, registers each 16-bit product, and accumulates N products into a block sum. The sum is presented on an output valid/ready handshake and held there until the consumer takes it.

Parameters:
N, 4, products per output block; legal range N >= 1
ACC_W, 24, accumulator and sum width; legal range ACC_W >= 16

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset: one clock domain, asynchronous assert, active-low; clears all state
clr  input  1  synchronous block abort/clear
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept an operand pair
a  input  8  multiplicand, unsigned
b  input  8  multiplier, unsigned
out_valid  output  1  block sum valid
out_ready  input  1  consumer accepts sum
sum  output  ACC_W  accumulated block sum, unsigned
ovf  output  1  sticky overflow flag for the current block

Behaviour:
- Product must come from an instantiated vedic_8X8; no behavioural multiply operator.
- State machine, two states:
  - ACC: collecting products.
  - HOLD: sum presented.
- Reset value of state is ACC.
- Counters:
  - cnt_in counts accepted pairs, 0..N.
  - cnt_acc counts accumulated products, 0..N.
- in_ready = (state==ACC) && (cnt_in < N) && !clr. It is combinational.
- Accept condition: in_valid && in_ready at a rising edge. Non-accepted cycles (bubbles) change nothing. in_valid with in_ready low is ignored.
- Stage 1: on accept, a_r <= a, b_r <= b, v1 <= 1 and cnt_in++. Otherwise v1 <= 0.
- Multiply: vedic_8X8(a_r, b_r) gives a combinational 16-bit product.
- Stage 2: p_r <= product, v2 <= v1.
- Accumulate: if v2, then acc <= acc + zero-extended p_r and cnt_acc++.
  - The addition is modulo 2^ACC_W.
  - A carry out of bit ACC_W-1 sets ovf. ovf is sticky until the block is emitted or cleared.
- When the add brings cnt_acc to N, the same edge moves state to HOLD.
- Latency: accepting the Nth pair at edge k raises out_valid after edge k+2. Back-to-back input gives one product per clock.
- HOLD:
  - out_valid = 1 and sum = acc, both registered and stable.
  - in_ready = 0.
  - Held for as long as out_ready stays low.
- Output handshake: out_valid && out_ready at an edge clears acc, cnt_in, cnt_acc and ovf, and returns state to ACC. in_ready is high in the following cycle. There is no same-cycle re-accept.
- In ACC state, sum shows the running acc and out_valid = 0.
- clr high at an edge:
  - Zeroes v1, v2, acc, cnt_in, cnt_acc and ovf; state returns to ACC.
  - Any product in flight is discarded.
  - Takes priority over accept, accumulate and output handshake.
  - A sum in HOLD is dropped without a handshake.
- rst_n low, asynchronously and at any time including mid-block or in HOLD:
  - Outputs: out_valid = 0, sum = 0, ovf = 0.
  - Internal state: all pipeline registers and counters 0, state ACC.
  - in_ready = 1 once rst_n is high and clr is low.
- N = 1: each accepted pair produces one output block containing its product.

Test Plan:
1. Pulse rst_n low mid-block with 2 pairs accepted and a product in flight -> out_valid=0, sum=0, ovf=0 immediately. After release, in_ready=1, and 4 pairs of (1,1) give sum=4.
2. Default N=4, back-to-back pairs (5,3),(4,2),(2,2),(6,8) -> in_ready low after the 4th accept, out_valid high 2 edges later, sum=75, ovf=0.
3. Same stream with in_valid bubbles between every pair -> sum=75; out_valid rises 2 edges after the 4th accept.
4. Stream of (255,255) x4 -> sum=260100 (0x03F804), ovf=0. Then hold out_ready low for 10 cycles while in_valid=1 -> sum stays stable, in_ready=0, no pairs consumed. Release out_ready -> the next block starts from 0.
5. ACC_W=16, N=2, stream (255,255) x2 -> sum=64514 (0xFC02), ovf=1. The next block (0,7),(3,3) gives sum=9, ovf=0.
6. Assert clr for one cycle after 2 pairs are accepted with one still in the pipeline, then send (6,8) x4 -> sum=192; the pre-clr products are not included.
